// File: rtl/sd_card_responder.sv
// SPI-mode SD card responder: decodes CMD17/CMD24 frames, answers R1,
// and serves 64-bit blocks with start token and CRC16 over MISO.
//
// state     | meaning
// IDLE      | MISO high, waiting for a frame start bit
// CMD_RX    | shifting the remaining 47 command bits
// CMD_CHK   | one cycle to validate the frame and latch R1
// RESP_WAIT | MISO high for RESP_DELAY cycles
// RESP_TX   | R1 on MISO, MSB first
// W_TOKEN   | waiting for the 0 that ends the 0xFE write token
// W_DATA_RX | shifting 64 data bits plus 16 CRC bits
// W_DRESP   | data-response byte on MISO
// W_BUSY    | MISO held low while the block is committed
// R_WAIT    | MISO high for DATA_DELAY cycles
// R_TX      | token, data and CRC16 on MISO
module sd_card_responder #(
    parameter int DEPTH       = 64,
    parameter int RESP_DELAY  = 2,
    parameter int DATA_DELAY  = 8,
    parameter int BUSY_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = 16;

    typedef enum logic [3:0] {
        IDLE, CMD_RX, CMD_CHK, RESP_WAIT, RESP_TX,
        W_TOKEN, W_DATA_RX, W_DRESP, W_BUSY, R_WAIT, R_TX
    } state_t;

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_64(input logic [63:0] d);
        logic [15:0] c;
        logic        fb;
        c = '0;
        for (int i = 63; i >= 0; i--) begin
            fb = d[i] ^ c[15];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            miso_d, err_d;
    logic            cmd_shift, data_shift, chk_load, wr_ok_load, commit;

    logic [47:0]     cmd_sr;
    logic [79:0]     data_sr;
    logic [7:0]      r1_q, r1_val;
    logic            is_wr_q, wr_ok_q, crc_ok;
    logic [AW-1:0]   addr_q;
    logic [87:0]     rd_frame_q;
    logic [63:0]     mem [DEPTH];

    logic [5:0]      cmd_idx;
    logic [31:0]     arg;
    logic [7:0]      dresp;

    assign cmd_idx = cmd_sr[45:40];
    assign arg     = cmd_sr[39:8];
    assign dresp   = wr_ok_q ? 8'b0000_0101 : 8'b0000_1011;
    // The final CRC bit is still on MOSI when the check is made.
    assign crc_ok  = (crc16_64(data_sr[78:15]) == {data_sr[14:0], MOSI});

    always_comb begin
        r1_val = 8'h00;
        if (!cmd_sr[46] || !cmd_sr[0] || (crc7_40(cmd_sr[47:8]) != cmd_sr[7:1]))
            r1_val = 8'h08;
        else if ((cmd_idx != 6'd17) && (cmd_idx != 6'd24))
            r1_val = 8'h04;
        else if (arg >= 32'(DEPTH))
            r1_val = 8'h40;
    end

    // MISO is registered from the next state so the wire always matches state_q.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        miso_d     = 1'b1;
        err_d      = 1'b0;
        cmd_shift  = 1'b0;
        data_shift = 1'b0;
        chk_load   = 1'b0;
        wr_ok_load = 1'b0;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!MOSI) begin
                    cmd_shift = 1'b1;
                    state_d   = CMD_RX;
                    cnt_d     = CW'(46);
                end
            end
            CMD_RX: begin
                cmd_shift = 1'b1;
                if (cnt_q == '0) state_d = CMD_CHK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            CMD_CHK: begin
                chk_load = 1'b1;
                state_d  = RESP_WAIT;
                cnt_d    = CW'(RESP_DELAY - 1);
            end
            RESP_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP_TX;
                    cnt_d   = CW'(7);
                    miso_d  = r1_q[7];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP_TX: begin
                if (cnt_q != '0) begin
                    cnt_d  = cnt_q - 1'b1;
                    miso_d = r1_q[cnt_d[2:0]];
                end else if (r1_q != 8'h00) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (is_wr_q) begin
                    state_d = W_TOKEN;
                end else begin
                    state_d = R_WAIT;
                    cnt_d   = CW'(DATA_DELAY - 1);
                end
            end
            W_TOKEN: begin
                if (!MOSI) begin
                    state_d = W_DATA_RX;
                    cnt_d   = CW'(79);
                end
            end
            W_DATA_RX: begin
                data_shift = 1'b1;
                if (cnt_q == '0) begin
                    state_d    = W_DRESP;
                    cnt_d      = CW'(7);
                    wr_ok_load = 1'b1;
                    miso_d     = 1'b0;  // MSB of both data responses
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            W_DRESP: begin
                if (cnt_q != '0) begin
                    cnt_d  = cnt_q - 1'b1;
                    miso_d = dresp[cnt_d[2:0]];
                end else if (wr_ok_q) begin
                    state_d = W_BUSY;
                    cnt_d   = CW'(BUSY_CYCLES - 1);
                    miso_d  = 1'b0;
                    commit  = 1'b1;
                end else begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            W_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d  = cnt_q - 1'b1;
                    miso_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            R_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = R_TX;
                    cnt_d   = CW'(87);
                    miso_d  = rd_frame_q[87];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            R_TX: begin
                if (cnt_q != '0) begin
                    cnt_d  = cnt_q - 1'b1;
                    miso_d = rd_frame_q[cnt_d[6:0]];
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            MISO       <= 1'b1;
            busy       <= 1'b0;
            err        <= 1'b0;
            cmd_sr     <= '0;
            data_sr    <= '0;
            r1_q       <= '0;
            is_wr_q    <= 1'b0;
            wr_ok_q    <= 1'b0;
            addr_q     <= '0;
            rd_frame_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            MISO    <= miso_d;
            err     <= err_d;
            busy    <= !((state_d == IDLE) || (state_d == CMD_RX));
            if (cmd_shift)  cmd_sr  <= {cmd_sr[46:0], MOSI};
            if (data_shift) data_sr <= {data_sr[78:0], MOSI};
            if (wr_ok_load) wr_ok_q <= crc_ok;
            if (chk_load) begin
                r1_q       <= r1_val;
                is_wr_q    <= (cmd_idx == 6'd24);
                addr_q     <= arg[AW-1:0];
                rd_frame_q <= {8'hFE, mem[arg[AW-1:0]], crc16_64(mem[arg[AW-1:0]])};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit) begin
            mem[addr_q] <= data_sr[79:16];
        end
    end

endmodule

// File: tb/tb_sd_card_responder.sv
// Directed bench for sd_card_responder: drives SPI frames on MOSI and
// compares MISO bit windows against hand-built expected frames.
module tb_sd_card_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic MOSI = 1'b1;
    logic MISO, busy, err;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    sd_card_responder dut (
        .clk  (clk),
        .rst_n(rst_n),
        .MOSI (MOSI),
        .MISO (MISO),
        .busy (busy),
        .err  (err)
    );

    always @(negedge clk) if (rst_n && err) err_cnt++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference CRCs by polynomial long division of the augmented message.
    function automatic logic [6:0] crc7_ref(input logic [39:0] d);
        logic [46:0] m;
        m = {d, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
        return m[6:0];
    endfunction

    function automatic logic [15:0] crc16_ref(input logic [63:0] d);
        logic [79:0] m;
        m = {d, 16'd0};
        for (int i = 79; i >= 16; i--)
            if (m[i]) m[i -: 17] = m[i -: 17] ^ 17'h1_1021;
        return m[15:0];
    endfunction

    function automatic logic [47:0] mk_frame(input logic [5:0] cmd, input logic [31:0] arg);
        logic [39:0] body;
        body = {2'b01, cmd, arg};
        return {body, crc7_ref(body), 1'b1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [127:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            MOSI = v[i];
            tick();
        end
        MOSI = 1'b1;
    endtask

    task automatic get_bits(input int n, output logic [127:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            v = {v[126:0], MISO};
            tick();
        end
    endtask

    // Sends a frame and checks busy, the idle gap and R1; returns just after R1.
    task automatic do_cmd(input logic [47:0] f, input logic [7:0] exp_r1, input string tag);
        logic [127:0] v;
        send_bits(128'(f), 48);
        check({tag, "_busy_start"}, 128'(busy), 128'(1'b1));
        get_bits(3, v);
        check({tag, "_resp_gap"}, v, 128'(3'b111));
        get_bits(8, v);
        check({tag, "_r1"}, v, 128'(exp_r1));
    endtask

    task automatic do_read(input logic [31:0] arg, input logic [63:0] data, input string tag);
        logic [127:0] v;
        do_cmd(mk_frame(6'd17, arg), 8'h00, tag);
        get_bits(96, v);
        check({tag, "_rd_frame"}, v, 128'({8'hFF, 8'hFE, data, crc16_ref(data)}));
        check({tag, "_rd_end"}, 128'({MISO, busy}), 128'(2'b10));
    endtask

    task automatic do_write(input logic [31:0] arg, input logic [63:0] data,
                            input logic [15:0] crc_xor, input bit exp_ok, input string tag);
        logic [127:0] v;
        do_cmd(mk_frame(6'd24, arg), 8'h00, tag);
        send_bits(128'(8'hFE), 8);
        send_bits(128'({data, crc16_ref(data) ^ crc_xor}), 80);
        get_bits(8, v);
        check({tag, "_dresp"}, v, exp_ok ? 128'(8'b0000_0101) : 128'(8'b0000_1011));
        if (exp_ok) begin
            get_bits(5, v);
            check({tag, "_busy_phase"}, v, 128'(5'b00001));
        end else begin
            get_bits(1, v);
            check({tag, "_no_busy"}, v, 128'(1'b1));
        end
        check({tag, "_wr_end_busy"}, 128'(busy), 128'(1'b0));
    endtask

    initial begin
        logic [47:0]  f;
        logic [127:0] v;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 128'({MISO, busy, err}), 128'(3'b100));
        rst_n = 1'b1;
        tick();

        do_read(32'd0, 64'd0, "rd0_after_reset");
        check("crc16_zero_block", 128'(crc16_ref(64'd0)), 128'(16'h0000));

        do_write(32'd5, 64'h0123_4567_89AB_CDEF, 16'h0000, 1'b1, "wr5");
        do_read(32'd5, 64'h0123_4567_89AB_CDEF, "rd5");
        check("err_none_yet", 128'(err_cnt), 128'(0));

        f = mk_frame(6'd17, 32'd5);
        f[1] = ~f[1];
        do_cmd(f, 8'h08, "crc7_bad");
        check("crc7_bad_busy_low", 128'({MISO, busy}), 128'(2'b10));
        get_bits(20, v);
        check("crc7_bad_no_token", v, 128'(20'hFFFFF));
        check("crc7_bad_err", 128'(err_cnt), 128'(1));

        do_cmd(mk_frame(6'd24, 32'd64), 8'h40, "addr_oob");
        tick();
        check("addr_oob_err", 128'(err_cnt), 128'(2));

        do_write(32'd3, 64'hDEAD_BEEF_0BAD_F00D, 16'h0001, 1'b0, "wr3_badcrc");
        check("wr3_badcrc_err", 128'(err_cnt), 128'(3));
        do_read(32'd3, 64'd0, "rd3_unchanged");

        do_cmd(mk_frame(6'd9, 32'd0), 8'h04, "cmd9");
        tick();
        f = mk_frame(6'd17, 32'd1);
        f[0] = 1'b0;
        do_cmd(f, 8'h08, "end_bit0");
        tick();
        check("illegal_cmd_err", 128'(err_cnt), 128'(5));

        do_cmd(mk_frame(6'd24, 32'd7), 8'h00, "wr7_abort");
        send_bits(128'(8'hFE), 8);
        send_bits(128'(30'h2AAA_5555), 30);
        rst_n = 1'b0;
        #1;
        check("abort_async_outputs", 128'({MISO, busy}), 128'(2'b10));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        do_read(32'd7, 64'd0, "rd7_discarded");
        do_read(32'd5, 64'd0, "rd5_cleared_by_reset");

        do_write(32'd63, 64'hFFFF_0000_A5A5_5A5A, 16'h0000, 1'b1, "wr63");
        do_read(32'd63, 64'hFFFF_0000_A5A5_5A5A, "rd63");
        check("err_final", 128'(err_cnt), 128'(5));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
